// File: rtl/timer_pkg.sv
// Shared definitions for the clock set-mode controller: state encoding,
// field widths/moduli and the wrap-around increment helpers.
package timer_pkg;

  localparam int HOURS_W     = 5;
  localparam int MINUTES_W   = 6;
  localparam int MINUTES_MOD = 60;
  localparam int HOURS_MOD   = 24;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_MIN  = 2'd1,
    SET_HOUR = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  // Sum is formed one bit wider than the field so 63+1 cannot silently wrap
  function automatic logic [MINUTES_W-1:0] next_minute(input logic [MINUTES_W-1:0] m);
    logic [MINUTES_W:0] sum;
    sum = {1'b0, m} + 7'd1;
    return (sum >= 7'(MINUTES_MOD)) ? '0 : sum[MINUTES_W-1:0];
  endfunction

  function automatic logic [HOURS_W-1:0] next_hour(input logic [HOURS_W-1:0] h);
    logic [HOURS_W:0] sum;
    sum = {1'b0, h} + 6'd1;
    return (sum >= 6'(HOURS_MOD)) ? '0 : sum[HOURS_W-1:0];
  endfunction

endpackage

// File: rtl/key_edge.sv
// Single-key rising-edge detector. The previous-level register resets to 1
// so a key already held when reset releases never produces an edge.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic key_rise
);

  logic prev_reg;

  // Track the key level from the previous cycle
  always_ff @(posedge clk) begin
    if (!reset) prev_reg <= 1'b1;
    else        prev_reg <= key;
  end

  assign key_rise = key && !prev_reg;

endmodule

// File: rtl/time_set_controller.sv
// Set-mode sequencer: edits a shadow copy of the time (minutes, then hours)
// and hands it to the timekeeper with a one-cycle load pulse. Abandons the
// edit on inactivity timeout or power loss.
module time_set_controller
  import timer_pkg::*;
#(
  parameter logic [31:0] IDLE_TIMEOUT = 32'd1000,
  parameter logic [31:0] BLINK_HALF   = 32'd50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 power_state,
  input  logic                 set_key,
  input  logic                 select_key,
  input  logic                 increase_key,
  input  logic [HOURS_W-1:0]   cur_hours,
  input  logic [MINUTES_W-1:0] cur_minutes,
  output logic                 set_mode,
  output logic                 set_select,
  output logic [HOURS_W-1:0]   edit_hours,
  output logic [MINUTES_W-1:0] edit_minutes,
  output logic                 load,
  output logic                 blank_hours,
  output logic                 blank_minutes
);

  // bit 0 = set, bit 1 = select, bit 2 = increase (highest priority first)
  logic [2:0] key_level;
  logic [2:0] key_rise;

  assign key_level = {increase_key, select_key, set_key};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      key_edge u_key_edge (
        .clk      (clk),
        .reset    (reset),
        .key      (key_level[gi]),
        .key_rise (key_rise[gi])
      );
    end
  endgenerate

  logic set_rise, sel_rise, inc_rise, in_set;

  assign set_rise = key_rise[0];
  assign sel_rise = key_rise[1] && !key_rise[0];
  assign inc_rise = key_rise[2] && !key_rise[1] && !key_rise[0];

  state_t                state_reg, state_next;
  logic [HOURS_W-1:0]    edit_hours_reg, edit_hours_next;
  logic [MINUTES_W-1:0]  edit_minutes_reg, edit_minutes_next;
  logic                  set_select_reg, set_select_next;
  logic                  load_reg, load_next;
  logic [31:0]           idle_cnt_reg, idle_cnt_next;
  logic [31:0]           blink_cnt_reg, blink_cnt_next;
  logic                  phase_reg, phase_next;
  logic                  set_mode_reg, blank_hours_reg, blank_minutes_reg;

  assign in_set = (state_reg == SET_MIN) || (state_reg == SET_HOUR);

  // Next-state, edit, timeout and blink logic
  always_comb begin
    state_next        = state_reg;
    edit_hours_next   = edit_hours_reg;
    edit_minutes_next = edit_minutes_reg;
    set_select_next   = set_select_reg;
    load_next         = 1'b0;
    idle_cnt_next     = 32'd0;
    blink_cnt_next    = 32'd0;
    phase_next        = 1'b0;

    if (in_set) begin
      idle_cnt_next = (key_rise != 3'b000) ? 32'd0 : idle_cnt_reg + 32'd1;
      if (blink_cnt_reg == BLINK_HALF - 32'd1) begin
        blink_cnt_next = 32'd0;
        phase_next     = !phase_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 32'd1;
        phase_next     = phase_reg;
      end
    end

    if (!power_state) begin
      // Power loss abandons any edit; no load is issued
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (set_rise) begin
            edit_hours_next   = cur_hours;
            edit_minutes_next = cur_minutes;
            set_select_next   = 1'b0;
            state_next        = SET_MIN;
          end
        end
        SET_MIN, SET_HOUR: begin
          if (set_rise) begin
            state_next = COMMIT;
            load_next  = 1'b1;
          end else if (sel_rise) begin
            state_next      = (state_reg == SET_MIN) ? SET_HOUR : SET_MIN;
            set_select_next = (state_reg == SET_MIN);
            blink_cnt_next  = 32'd0;
            phase_next      = 1'b0;
          end else if (inc_rise) begin
            if (state_reg == SET_MIN) edit_minutes_next = next_minute(edit_minutes_reg);
            else                      edit_hours_next   = next_hour(edit_hours_reg);
          end else if (idle_cnt_reg == IDLE_TIMEOUT - 32'd1) begin
            state_next = IDLE;
          end
        end
        COMMIT:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State and registered outputs; blanks derived from next state/phase so they align with set_mode
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= IDLE;
      edit_hours_reg    <= '0;
      edit_minutes_reg  <= '0;
      set_select_reg    <= 1'b0;
      load_reg          <= 1'b0;
      idle_cnt_reg      <= 32'd0;
      blink_cnt_reg     <= 32'd0;
      phase_reg         <= 1'b0;
      set_mode_reg      <= 1'b0;
      blank_hours_reg   <= 1'b0;
      blank_minutes_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      edit_hours_reg    <= edit_hours_next;
      edit_minutes_reg  <= edit_minutes_next;
      set_select_reg    <= set_select_next;
      load_reg          <= load_next;
      idle_cnt_reg      <= idle_cnt_next;
      blink_cnt_reg     <= blink_cnt_next;
      phase_reg         <= phase_next;
      set_mode_reg      <= (state_next != IDLE);
      blank_hours_reg   <= (state_next == SET_HOUR) && phase_next;
      blank_minutes_reg <= (state_next == SET_MIN) && phase_next;
    end
  end

  assign set_mode      = set_mode_reg;
  assign set_select    = set_select_reg;
  assign edit_hours    = edit_hours_reg;
  assign edit_minutes  = edit_minutes_reg;
  assign load          = load_reg;
  assign blank_hours   = blank_hours_reg;
  assign blank_minutes = blank_minutes_reg;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with short timeout/blink parameters.
module tb_time_set_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       power_state;
  logic       set_key, select_key, increase_key;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       set_mode, set_select, load, blank_hours, blank_minutes;
  logic [4:0] edit_hours;
  logic [5:0] edit_minutes;

  int checks = 0;
  int errors = 0;
  logic load_seen;

  time_set_controller #(
    .IDLE_TIMEOUT (32'd20),
    .BLINK_HALF   (32'd4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .power_state   (power_state),
    .set_key       (set_key),
    .select_key    (select_key),
    .increase_key  (increase_key),
    .cur_hours     (cur_hours),
    .cur_minutes   (cur_minutes),
    .set_mode      (set_mode),
    .set_select    (set_select),
    .edit_hours    (edit_hours),
    .edit_minutes  (edit_minutes),
    .load          (load),
    .blank_hours   (blank_hours),
    .blank_minutes (blank_minutes)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic pulse_inc();
    increase_key = 1'b1; tick();
    increase_key = 1'b0; tick();
  endtask

  initial begin
    reset = 1'b0; power_state = 1'b1;
    set_key = 1'b0; select_key = 1'b0; increase_key = 1'b0;
    cur_hours = 5'd13; cur_minutes = 6'd45;
    tick(); tick();
    chk("reset_set_mode", set_mode, 0);
    chk("reset_edit_hours", edit_hours, 0);
    chk("reset_edit_minutes", edit_minutes, 0);
    chk("reset_load", load, 0);
    chk("reset_blank_min", blank_minutes, 0);
    chk("reset_blank_hr", blank_hours, 0);
    reset = 1'b1; tick();

    // Enter set mode with 13:45
    set_key = 1'b1; tick();
    chk("enter_set_mode", set_mode, 1);
    chk("enter_edit_hours", edit_hours, 13);
    chk("enter_edit_minutes", edit_minutes, 45);
    chk("enter_set_select", set_select, 0);
    chk("enter_load", load, 0);
    set_key = 1'b0; tick();

    // Minutes up to 58, then wrap through 59, 0, 1
    for (int i = 0; i < 13; i++) pulse_inc();
    chk("min_at_58", edit_minutes, 58);
    pulse_inc(); chk("min_59", edit_minutes, 59);
    pulse_inc(); chk("min_wrap_0", edit_minutes, 0);
    pulse_inc(); chk("min_1", edit_minutes, 1);
    chk("hours_unchanged", edit_hours, 13);

    // Hour field: 13 -> 23 -> wrap 0
    select_key = 1'b1; tick();
    chk("select_hour", set_select, 1);
    select_key = 1'b0; tick();
    for (int i = 0; i < 10; i++) pulse_inc();
    chk("hour_at_23", edit_hours, 23);
    pulse_inc(); chk("hour_wrap_0", edit_hours, 0);
    chk("min_after_hour", edit_minutes, 1);

    // Commit 00:01
    set_key = 1'b1; tick();
    chk("commit_load", load, 1);
    chk("commit_set_mode", set_mode, 1);
    chk("commit_edit_hours", edit_hours, 0);
    chk("commit_edit_minutes", edit_minutes, 1);
    set_key = 1'b0; tick();
    chk("after_commit_load", load, 0);
    chk("after_commit_mode", set_mode, 0);

    // set and increase rising together: set wins, minutes untouched
    set_key = 1'b1; tick();
    chk("reenter_minutes", edit_minutes, 45);
    set_key = 1'b0; tick();
    set_key = 1'b1; increase_key = 1'b1; tick();
    chk("same_cycle_load", load, 1);
    chk("same_cycle_minutes", edit_minutes, 45);
    set_key = 1'b0; increase_key = 1'b0; tick();
    chk("same_cycle_mode_off", set_mode, 0);

    // Timeout: 20 idle cycles after last accepted edge abandons edit
    set_key = 1'b1; tick();
    set_key = 1'b0; tick();
    increase_key = 1'b1; tick();
    chk("timeout_edit_46", edit_minutes, 46);
    increase_key = 1'b0;
    load_seen = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      load_seen = load_seen | load;
    end
    chk("timeout_not_yet", set_mode, 1);
    tick();
    load_seen = load_seen | load;
    chk("timeout_mode_off", set_mode, 0);
    tick();
    load_seen = load_seen | load;
    chk("timeout_no_load", load_seen, 0);

    // Power loss mid-edit
    set_key = 1'b1; tick();
    set_key = 1'b0; tick();
    pulse_inc();
    power_state = 1'b0; tick();
    chk("power_mode_off", set_mode, 0);
    chk("power_no_load", load, 0);
    set_key = 1'b1; tick();
    chk("power_off_no_enter", set_mode, 0);
    set_key = 1'b0; power_state = 1'b1; tick();

    // Reset mid-edit, with increase held across reset release
    set_key = 1'b1; tick();
    set_key = 1'b0; tick();
    pulse_inc();
    reset = 1'b0; increase_key = 1'b1; tick();
    chk("rst_mid_mode", set_mode, 0);
    chk("rst_mid_edit_hours", edit_hours, 0);
    chk("rst_mid_edit_minutes", edit_minutes, 0);
    chk("rst_mid_load", load, 0);
    reset = 1'b1; tick();

    // Enter with increase still held; check blink timing (BLINK_HALF = 4)
    set_key = 1'b1; tick();
    chk("held_enter_mode", set_mode, 1);
    chk("blink_e0", blank_minutes, 0);
    set_key = 1'b0; tick();
    tick(); tick();
    chk("blink_e3", blank_minutes, 0);
    tick();
    chk("blink_e4", blank_minutes, 1);
    chk("blink_e4_hours", blank_hours, 0);
    tick(); tick(); tick();
    chk("blink_e7", blank_minutes, 1);
    tick();
    chk("blink_e8", blank_minutes, 0);
    chk("blink_e8_hours", blank_hours, 0);
    chk("held_no_increment", edit_minutes, 45);
    increase_key = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
# time_set_controller

Sequencing controller for the clock timekeeper. It owns the user-facing set mode. It edge-detects the three panel keys, runs the minute/hour edit state machine on a shadow copy of the current time, and commits the edited time to the timekeeper with a one-cycle load pulse. It sits between the key inputs and the timekeeper. The timekeeper counts only while this block reports `set_mode` low.

## Interface
Parameters:
- `IDLE_TIMEOUT`, default 32'd1000: number of cycles without any accepted key edge in a set state before set mode is abandoned.
- `BLINK_HALF`, default 32'd50: number of cycles per blink half-period for the selected field.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `power_state` in 1: 1 means the appliance is powered on.
- `set_key` in 1: level input from the key; toggles set mode (enter / commit).
- `select_key` in 1: level input from the key; toggles the edited field.
- `increase_key` in 1: level input from the key; increments the edited field.
- `cur_hours` in 5: live hours from the timekeeper, range 0–23.
- `cur_minutes` in 6: live minutes from the timekeeper, range 0–59.
- `set_mode` out 1: high in any set state; the timekeeper halts counting while it is high.
- `set_select` out 1: 0 means the minute field is edited, 1 means the hour field is edited.
- `edit_hours` out 5: shadow hours value.
- `edit_minutes` out 6: shadow minutes value.
- `load` out 1: one-cycle pulse; the timekeeper loads `edit_*` and zeroes seconds.
- `blank_hours` out 1: display blanks the hour digits while high.
- `blank_minutes` out 1: display blanks the minute digits while high.

## Operation
- Edge detect: each key has a previous-level register. An edge is `key && !prev`. The previous-level registers reset to 1, so a key held through reset never fires an edge.
- Key priority per cycle: `set_key` > `select_key` > `increase_key`. At most one edge is acted on per cycle; the lower-priority edges that cycle are discarded.
- IDLE state:
  - On a `set_key` edge with `power_state`=1: copy `cur_hours`/`cur_minutes` into `edit_*`, set `set_select`=0, go to SET_MIN.
  - All other key edges are ignored.
- SET_MIN state:
  - `increase_key` edge: `edit_minutes` becomes (`edit_minutes`+1) mod 60, so 59 wraps to 0.
  - `select_key` edge: go to SET_HOUR and set `set_select`=1.
  - `set_key` edge: go to COMMIT.
- SET_HOUR state:
  - `increase_key` edge: `edit_hours` becomes (`edit_hours`+1) mod 24, so 23 wraps to 0.
  - `select_key` edge: go to SET_MIN and set `set_select`=0.
  - `set_key` edge: go to COMMIT.
- COMMIT state: `load`=1 for exactly this one cycle, then go to IDLE. Key edges arriving in COMMIT are dropped.
- Timeout: an idle counter clears on every accepted key edge and on entry to a set state. When it reaches `IDLE_TIMEOUT`-1 in SET_MIN or SET_HOUR, go to IDLE without a load; the edits are discarded.
- Power loss: `power_state`=0 in any state forces IDLE on the next edge with no load. This overrides every key.
- Blink:
  - The blink counter and phase clear on entry to SET_MIN or SET_HOUR and on every `select_key` edge.
  - The phase toggles every `BLINK_HALF` cycles.
  - `blank_minutes` = SET_MIN && phase. `blank_hours` = SET_HOUR && phase.
  - Both blank outputs are 0 outside set states.
- Width: arithmetic is done at field width+1 before the modulo, so no silent wrap at 64 or 32.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including `edit_hours`, `edit_minutes`, `load` and both blank outputs.
  - Counters 0; previous-level key registers 1.
- All outputs are registered, with no combinational path from input to output.
- A key rises at cycle N; the corresponding `edit_*`, `set_select` or `set_mode` change is visible after edge N+1.
- After a `set_key` edge in a set state, `load` is high for exactly one cycle (the COMMIT cycle). `set_mode` stays high through that COMMIT cycle and drops the cycle after.
- `edit_*` values are held stable while `load` is high.
- `set_mode` rises in the same cycle that `edit_*` captures `cur_*`.
- Reset asserted mid-edit: the block returns to IDLE on the next edge, with no load and `edit_*` cleared.

## Structure
- Shared package `timer_pkg`:
  - State encoding (IDLE, SET_MIN, SET_HOUR, COMMIT).
  - `MINUTES_MOD`=60 and `HOURS_MOD`=24.
  - Field widths 5/6.
- Sub-module `key_edge`: single-key rising-edge detector (prev register resetting to 1). It is instantiated three times.

## Test plan
- Reset, then `set_key` pulse with `cur`=13:45 -> `set_mode`=1, `edit`=13:45, `set_select`=0, `load`=0.
- In SET_MIN at 58, three `increase_key` pulses -> `edit_minutes` goes 59, 0, 1; `edit_hours` is unchanged.
- `select_key` pulse, then `increase_key` from hour 23 -> `set_select`=1, `edit_hours`=0; then `set_key` -> single-cycle `load` with `edit`=00:01, then `set_mode`=0.
- `set_key` and `increase_key` rising in the same cycle while in SET_MIN -> COMMIT occurs and the minute value is unchanged.
- Enter set mode and edit, then no keys for `IDLE_TIMEOUT` cycles; separately, drop `power_state` mid-edit -> return to IDLE with `load` never asserted.
- Hold `increase_key` high across reset release -> no increment occurs; in SET_MIN, `blank_minutes` toggles every `BLINK_HALF` cycles and `blank_hours` stays 0.
